// File: rtl/load_store_unit_pkg.sv
// Shared LSU definitions: data width, FSM state encoding, RV32I width codes.
// Latency: n/a (types, constants and pure functions only).
// Backpressure: n/a.
package load_store_unit_pkg;

    localparam int WORD_SIZE = 32;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_RESP = 2'd2,
        ST_ERR  = 2'd3
    } lsu_state_t;

    // RV32I funct3 width codes (loads use all five, stores the first three)
    localparam logic [2:0] F3_B  = 3'b000;
    localparam logic [2:0] F3_H  = 3'b001;
    localparam logic [2:0] F3_W  = 3'b010;
    localparam logic [2:0] F3_BU = 3'b100;
    localparam logic [2:0] F3_HU = 3'b101;

    // Unsigned widths only exist for loads
    function automatic logic f3_legal(input logic we, input logic [2:0] f3);
        case (f3)
            F3_B, F3_H, F3_W: return 1'b1;
            F3_BU, F3_HU:     return ~we;
            default:          return 1'b0;
        endcase
    endfunction

    function automatic logic f3_aligned(input logic [2:0] f3, input logic [1:0] off);
        case (f3)
            F3_H, F3_HU: return ~off[0];
            F3_W:        return (off == 2'b00);
            default:     return 1'b1;
        endcase
    endfunction

    // Low two funct3 bits give the access size for both loads and stores
    function automatic logic [3:0] byte_en(input logic [2:0] f3, input logic [1:0] off);
        case (f3[1:0])
            2'b00:   return 4'b0001 << off;
            2'b01:   return 4'b0011 << off;
            default: return 4'b1111;
        endcase
    endfunction

endpackage

// File: rtl/load_store_unit_align.sv
// Load lane selection and sign/zero extension of a memory word.
// Latency: purely combinational.
// Backpressure: none; output follows inputs.
import load_store_unit_pkg::*;

module load_store_unit_align #(
    parameter int WORD_SIZE = load_store_unit_pkg::WORD_SIZE
) (
    input  logic [WORD_SIZE-1:0] word,
    input  logic [1:0]           offset,
    input  logic [2:0]           funct3,
    output logic [WORD_SIZE-1:0] rdata
);

    logic [7:0]  lane_b;
    logic [15:0] lane_h;

    // Pick the addressed byte/halfword, then extend per width code
    always_comb begin
        lane_b = 8'h00;
        lane_h = 16'h0000;
        rdata  = word;
        case (offset)
            2'd0:    lane_b = word[7:0];
            2'd1:    lane_b = word[15:8];
            2'd2:    lane_b = word[23:16];
            default: lane_b = word[31:24];
        endcase
        lane_h = offset[1] ? word[31:16] : word[15:0];
        case (funct3)
            F3_B:    rdata = {{(WORD_SIZE-8){lane_b[7]}}, lane_b};
            F3_BU:   rdata = {{(WORD_SIZE-8){1'b0}}, lane_b};
            F3_H:    rdata = {{(WORD_SIZE-16){lane_h[15]}}, lane_h};
            F3_HU:   rdata = {{(WORD_SIZE-16){1'b0}}, lane_h};
            default: rdata = word;
        endcase
    end

endmodule

// File: rtl/load_store_unit.sv
// RV32I load/store unit: checks, issues one word-aligned memory access, extends loads.
// Latency: done 2 cycles after request with immediate ack (+1 per wait cycle); faults in 1.
// Backpressure: holds the memory request stable until i_MemAck; busy blocks new requests.
import load_store_unit_pkg::*;

module load_store_unit #(
    parameter int WORD_SIZE = load_store_unit_pkg::WORD_SIZE
) (
    input  logic                 i_clk,
    input  logic                 i_rst_n,
    input  logic                 i_Req,
    input  logic                 i_We,
    input  logic [2:0]           i_Funct3,
    input  logic [WORD_SIZE-1:0] i_Addr,
    input  logic [WORD_SIZE-1:0] i_WData,
    output logic                 o_Busy,
    output logic                 o_Done,
    output logic                 o_Fault,
    output logic [WORD_SIZE-1:0] o_RData,
    output logic                 o_MemReq,
    output logic                 o_MemWe,
    output logic [WORD_SIZE-1:0] o_MemAddr,
    output logic [WORD_SIZE-1:0] o_MemWData,
    output logic [3:0]           o_MemBe,
    input  logic                 i_MemAck,
    input  logic [WORD_SIZE-1:0] i_MemRData
);

    lsu_state_t           state;
    logic                 we_q;
    logic [2:0]           funct3_q;
    logic [WORD_SIZE-1:0] addr_q;
    logic [WORD_SIZE-1:0] wdata_q;
    logic [WORD_SIZE-1:0] load_data;
    logic                 req_ok;

    assign req_ok    = f3_legal(i_We, i_Funct3) && f3_aligned(i_Funct3, i_Addr[1:0]);
    assign o_MemAddr = {addr_q[WORD_SIZE-1:2], 2'b00};

    // Replicate store data across every lane the access size can occupy
    always_comb begin
        o_MemWData = wdata_q;
        case (funct3_q[1:0])
            2'b00:   o_MemWData = {4{wdata_q[7:0]}};
            2'b01:   o_MemWData = {2{wdata_q[15:0]}};
            default: o_MemWData = wdata_q;
        endcase
    end

    load_store_unit_align #(.WORD_SIZE(WORD_SIZE)) u_align (
        .word   (i_MemRData),
        .offset (addr_q[1:0]),
        .funct3 (funct3_q),
        .rdata  (load_data)
    );

    // Access FSM with registered handshake/status outputs
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state    <= ST_IDLE;
            we_q     <= 1'b0;
            funct3_q <= 3'b000;
            addr_q   <= '0;
            wdata_q  <= '0;
            o_Busy   <= 1'b0;
            o_Done   <= 1'b0;
            o_Fault  <= 1'b0;
            o_RData  <= '0;
            o_MemReq <= 1'b0;
            o_MemWe  <= 1'b0;
            o_MemBe  <= 4'b0000;
        end else begin
            o_Done  <= 1'b0;
            o_Fault <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (i_Req && req_ok) begin
                        state    <= ST_WAIT;
                        we_q     <= i_We;
                        funct3_q <= i_Funct3;
                        addr_q   <= i_Addr;
                        wdata_q  <= i_WData;
                        o_Busy   <= 1'b1;
                        o_MemReq <= 1'b1;
                        o_MemWe  <= i_We;
                        o_MemBe  <= byte_en(i_Funct3, i_Addr[1:0]);
                    end else if (i_Req) begin
                        // Rejected access never reaches memory
                        state   <= ST_ERR;
                        o_Busy  <= 1'b1;
                        o_Done  <= 1'b1;
                        o_Fault <= 1'b1;
                    end
                end
                ST_WAIT: begin
                    if (i_MemAck) begin
                        state    <= ST_RESP;
                        o_Done   <= 1'b1;
                        o_MemReq <= 1'b0;
                        o_MemWe  <= 1'b0;
                        o_MemBe  <= 4'b0000;
                        if (!we_q) begin
                            o_RData <= load_data;
                        end
                    end
                end
                default: begin
                    // RESP and ERR both last exactly one cycle
                    state  <= ST_IDLE;
                    o_Busy <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_load_store_unit.sv
module tb_load_store_unit;

    logic        clk;
    logic        rst_n;
    logic        req;
    logic        we;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] wdata;
    logic        busy;
    logic        done;
    logic        fault;
    logic [31:0] rdata;
    logic        mem_req;
    logic        mem_we;
    logic [31:0] mem_addr;
    logic [31:0] mem_wdata;
    logic [3:0]  mem_be;
    logic        mem_ack;
    logic [31:0] mem_rdata;

    int vectors;
    int miscompares;

    load_store_unit #(.WORD_SIZE(32)) dut (
        .i_clk      (clk),
        .i_rst_n    (rst_n),
        .i_Req      (req),
        .i_We       (we),
        .i_Funct3   (funct3),
        .i_Addr     (addr),
        .i_WData    (wdata),
        .o_Busy     (busy),
        .o_Done     (done),
        .o_Fault    (fault),
        .o_RData    (rdata),
        .o_MemReq   (mem_req),
        .o_MemWe    (mem_we),
        .o_MemAddr  (mem_addr),
        .o_MemWData (mem_wdata),
        .o_MemBe    (mem_be),
        .i_MemAck   (mem_ack),
        .i_MemRData (mem_rdata)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=0x%08h expected=0x%08h", tag, obs, exp);
        end
    endtask

    // Advance one clock; outputs are sampled 1ns after the rising edge
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic w, input logic [2:0] f3, input logic [31:0] a, input logic [31:0] d);
        req = 1'b1; we = w; funct3 = f3; addr = a; wdata = d;
    endtask

    initial begin
        vectors = 0;
        miscompares = 0;
        rst_n = 1'b0; req = 1'b0; we = 1'b0; funct3 = 3'b000;
        addr = '0; wdata = '0; mem_ack = 1'b0; mem_rdata = '0;
        #12;
        check("rst_busy", {31'd0, busy}, 32'd0);
        check("rst_done", {31'd0, done}, 32'd0);
        check("rst_fault", {31'd0, fault}, 32'd0);
        check("rst_memreq", {31'd0, mem_req}, 32'd0);
        check("rst_memwe", {31'd0, mem_we}, 32'd0);
        check("rst_membe", {28'd0, mem_be}, 32'd0);
        check("rst_rdata", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();

        // LB at 0x103, ack in first WAIT cycle
        issue(1'b0, 3'b000, 32'h103, 32'h0);
        tick();
        req = 1'b0;
        check("lb_memreq", {31'd0, mem_req}, 32'd1);
        check("lb_memaddr", mem_addr, 32'h100);
        check("lb_membe", {28'd0, mem_be}, 32'h8);
        check("lb_memwe", {31'd0, mem_we}, 32'd0);
        check("lb_busy", {31'd0, busy}, 32'd1);
        check("lb_nodone_early", {31'd0, done}, 32'd0);
        mem_ack = 1'b1; mem_rdata = 32'h80FF1234;
        tick();
        mem_ack = 1'b0;
        check("lb_done", {31'd0, done}, 32'd1);
        check("lb_fault", {31'd0, fault}, 32'd0);
        check("lb_rdata", rdata, 32'hFFFFFF80);
        check("lb_memreq_off", {31'd0, mem_req}, 32'd0);
        check("lb_membe_off", {28'd0, mem_be}, 32'd0);
        tick();
        check("lb_done_pulse", {31'd0, done}, 32'd0);
        check("lb_idle", {31'd0, busy}, 32'd0);

        // LHU at 0x102, ack after 3 wait cycles
        issue(1'b0, 3'b101, 32'h102, 32'h0);
        tick();
        req = 1'b0;
        for (int i = 0; i < 3; i++) begin
            check("lhu_hold_req", {31'd0, mem_req}, 32'd1);
            check("lhu_hold_addr", mem_addr, 32'h100);
            check("lhu_hold_be", {28'd0, mem_be}, 32'hC);
            check("lhu_hold_nodone", {31'd0, done}, 32'd0);
            tick();
        end
        check("lhu_req_cycle4", {31'd0, mem_req}, 32'd1);
        check("lhu_be_cycle4", {28'd0, mem_be}, 32'hC);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        check("lhu_done", {31'd0, done}, 32'd1);
        check("lhu_rdata", rdata, 32'h000080FF);
        tick();

        // SB at 0x101: replicated data, read data held
        issue(1'b1, 3'b000, 32'h101, 32'h000000A5);
        tick();
        req = 1'b0;
        check("sb_memwe", {31'd0, mem_we}, 32'd1);
        check("sb_memaddr", mem_addr, 32'h100);
        check("sb_membe", {28'd0, mem_be}, 32'h2);
        check("sb_wdata", mem_wdata, 32'hA5A5A5A5);
        mem_ack = 1'b1; mem_rdata = 32'hDEADBEEF;
        tick();
        mem_ack = 1'b0;
        check("sb_done", {31'd0, done}, 32'd1);
        check("sb_rdata_held", rdata, 32'h000080FF);
        tick();

        // SH at 0x102
        issue(1'b1, 3'b001, 32'h102, 32'h1234BEEF);
        tick();
        req = 1'b0;
        check("sh_membe", {28'd0, mem_be}, 32'hC);
        check("sh_wdata", mem_wdata, 32'hBEEFBEEF);
        mem_ack = 1'b1;
        tick();
        mem_ack = 1'b0;
        tick();

        // LH at 0x000, sign extension of halfword
        issue(1'b0, 3'b001, 32'h0, 32'h0);
        tick();
        req = 1'b0;
        check("lh_membe", {28'd0, mem_be}, 32'h3);
        mem_ack = 1'b1; mem_rdata = 32'h00008001;
        tick();
        mem_ack = 1'b0;
        check("lh_rdata", rdata, 32'hFFFF8001);
        tick();

        // LW at 0x004 passes the word through
        issue(1'b0, 3'b010, 32'h4, 32'h0);
        tick();
        req = 1'b0;
        check("lw_membe", {28'd0, mem_be}, 32'hF);
        check("lw_memaddr", mem_addr, 32'h4);
        mem_ack = 1'b1; mem_rdata = 32'h89ABCDEF;
        tick();
        mem_ack = 1'b0;
        check("lw_rdata", rdata, 32'h89ABCDEF);
        tick();

        // Misaligned LW at 0x102
        issue(1'b0, 3'b010, 32'h102, 32'h0);
        tick();
        req = 1'b0;
        check("mis_done", {31'd0, done}, 32'd1);
        check("mis_fault", {31'd0, fault}, 32'd1);
        check("mis_memreq", {31'd0, mem_req}, 32'd0);
        check("mis_rdata_held", rdata, 32'h89ABCDEF);
        tick();
        check("mis_done_pulse", {31'd0, done}, 32'd0);
        check("mis_idle", {31'd0, busy}, 32'd0);

        // Illegal load funct3 3'b011
        issue(1'b0, 3'b011, 32'h0, 32'h0);
        tick();
        req = 1'b0;
        check("ill_done", {31'd0, done}, 32'd1);
        check("ill_fault", {31'd0, fault}, 32'd1);
        check("ill_memreq", {31'd0, mem_req}, 32'd0);
        tick();

        // Illegal store funct3 3'b100 (no unsigned stores)
        issue(1'b1, 3'b100, 32'h0, 32'h0);
        tick();
        req = 1'b0;
        check("ill_st_fault", {31'd0, fault}, 32'd1);
        check("ill_st_memreq", {31'd0, mem_req}, 32'd0);
        tick();

        // Reset mid-WAIT abandons the transaction
        issue(1'b0, 3'b010, 32'h8, 32'h0);
        tick();
        req = 1'b0;
        check("rw_memreq_before", {31'd0, mem_req}, 32'd1);
        rst_n = 1'b0;
        #1;
        check("rw_memreq_async", {31'd0, mem_req}, 32'd0);
        check("rw_busy_async", {31'd0, busy}, 32'd0);
        check("rw_rdata_clear", rdata, 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        mem_ack = 1'b1; mem_rdata = 32'h11111111;
        tick();
        mem_ack = 1'b0;
        check("rw_late_ack_done", {31'd0, done}, 32'd0);
        check("rw_late_ack_busy", {31'd0, busy}, 32'd0);
        check("rw_late_ack_rdata", rdata, 32'd0);
        tick();

        // Request held high during WAIT: one transaction only
        issue(1'b0, 3'b010, 32'h0, 32'h0);
        tick();
        check("hold_wait1", {31'd0, mem_req}, 32'd1);
        tick();
        check("hold_wait2", {31'd0, mem_req}, 32'd1);
        mem_ack = 1'b1; mem_rdata = 32'h12345678;
        tick();
        mem_ack = 1'b0;
        check("hold_done", {31'd0, done}, 32'd1);
        check("hold_rdata", rdata, 32'h12345678);
        tick();
        req = 1'b0;
        check("hold_no_second_done", {31'd0, done}, 32'd0);
        check("hold_idle", {31'd0, busy}, 32'd0);
        check("hold_no_memreq", {31'd0, mem_req}, 32'd0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter WORD_SIZE, default 32, meaning data and address width; the value SHALL come from the shared parameters header.
REQ-002 The block SHALL have these ports, clock and reset first:
- i_clk  in  1  single clock, rising edge.
- i_rst_n  in  1  asynchronous, active-low reset.
- i_Req  in  1  access request from execute stage.
- i_We  in  1  1=store, 0=load.
- i_Funct3  in  3  RV32I width code: LB/LH/LW/LBU/LHU, SB/SH/SW.
- i_Addr  in  WORD_SIZE  effective address (ALU ADD result).
- i_WData  in  WORD_SIZE  store data (rs2).
- o_Busy  out  1  high whenever state is not IDLE.
- o_Done  out  1  one-cycle completion pulse.
- o_Fault  out  1  valid with o_Done; misaligned address or illegal funct3.
- o_RData  out  WORD_SIZE  extended load result.
- o_MemReq  out  1  memory request.
- o_MemWe  out  1  memory write.
- o_MemAddr  out  WORD_SIZE  word-aligned address, bits [1:0]=0.
- o_MemWData  out  WORD_SIZE  lane-replicated store data.
- o_MemBe  out  4  byte enables.
- i_MemAck  in  1  memory accept/complete.
- i_MemRData  in  WORD_SIZE  memory read word, valid with i_MemAck.

Function
REQ-003 FSM states SHALL be IDLE, WAIT, RESP, ERR.
REQ-004 IDLE + i_Req with legal, aligned access SHALL latch i_We, i_Funct3, i_Addr and i_WData, then go to WAIT.
REQ-005 IDLE + i_Req with illegal funct3 or misalignment SHALL go to ERR; no memory request SHALL be issued.
- Misaligned: halfword with addr[0]=1; word with addr[1:0]!=0.
- Illegal funct3: any load or store code not listed in REQ-002.
REQ-006 WAIT SHALL assert o_MemReq; o_MemWe, o_MemAddr, o_MemWData and o_MemBe SHALL stay constant until i_MemAck; i_MemAck SHALL move the state to RESP.
REQ-007 RESP SHALL assert o_Done=1 and o_Fault=0 for one cycle, then go to IDLE.
REQ-008 ERR SHALL assert o_Done=1 and o_Fault=1 for one cycle, then go to IDLE.
REQ-009 Latency:
- With i_MemAck in the first WAIT cycle, o_Done SHALL rise 2 cycles after i_Req is sampled.
- Each wait cycle SHALL add 1 cycle.
- ERR completion SHALL take 1 cycle.
REQ-010 i_Req outside IDLE SHALL be ignored; i_MemAck outside WAIT SHALL be ignored.
REQ-011 Byte enables SHALL be SB=4'b0001<<addr[1:0], SH=4'b0011<<addr[1:0], SW=4'b1111, and loads SHALL use the same enables.
REQ-012 Store data SHALL be replicated: SB={4{wdata[7:0]}}, SH={2{wdata[15:0]}}, SW=wdata.
REQ-013 Load data SHALL select the lane by latched addr[1:0] and extend it:
- LB/LH sign-extend.
- LBU/LHU zero-extend.
- LW passes the word unchanged.
REQ-014 o_RData SHALL be registered and update only on a load's i_MemAck; it SHALL hold across stores and faults.
REQ-015 When not in WAIT, o_MemReq SHALL be 0 and o_MemBe SHALL be 0.

Reset
REQ-016 i_rst_n=0 SHALL asynchronously force:
- state=IDLE;
- o_MemReq, o_Done, o_Fault, o_Busy, o_MemWe = 0;
- o_MemBe=0, o_RData=0, latched registers=0.
REQ-017 Reset during WAIT SHALL drop o_MemReq immediately; that transaction SHALL be abandoned and any later i_MemAck ignored.

Structure
REQ-018 LSU state encodings and funct3 width codes SHALL live in the shared defines headers (LSU_DEFINES.vh, OPCODES_DEFINES.vh).
REQ-019 Lane selection plus extension SHALL be one combinational sub-module, lsu_align.

Verification
REQ-020 LB at 0x103, mem word 0x80FF1234, ack in the first WAIT cycle -> o_MemAddr=0x100, o_MemBe=4'b1000, o_Done 2 cycles after i_Req, o_RData=0xFFFFFF80.
REQ-021 LHU at 0x102, same word, ack delayed 3 cycles -> request signals stable for 4 cycles, o_Done 1 cycle after ack, o_RData=0x000080FF.
REQ-022 SB at 0x101, i_WData=0x000000A5 -> o_MemWe=1, o_MemAddr=0x100, o_MemBe=4'b0010, o_MemWData=0xA5A5A5A5, o_RData unchanged.
REQ-023 LW at 0x102; then funct3=3'b011 load -> o_MemReq never asserted, o_Done=o_Fault=1 one cycle after each request.
REQ-024 i_rst_n=0 mid-WAIT, then ack pulse after reset release -> o_MemReq=0 immediately, o_Done stays 0, state IDLE.
REQ-025 i_Req held high during WAIT -> only one memory transaction and one o_Done per accepted request.
